fpu_sqrt_seq: RTL and testbench
===============================

FPU_SQRT_SEQ -- requirements
Module: fpu_sqrt_seq

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, exponent field width.
REQ-002 SHALL have parameter MANT_WIDTH, default 23, stored fraction width.
REQ-003 SHALL have parameter BITS_PER_CYCLE, default 1, root bits resolved per iteration; legal values are 1 and 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, operand present.
REQ-007 SHALL have port in_ready, output, 1, block can accept.
REQ-008 SHALL have ports in_sign / in_exponent / in_mantissa, inputs, 1 / EXP_WIDTH / MANT_WIDTH, IEEE operand fields.
REQ-009 SHALL have port in_mode, input, 3, rounding mode, passed through unchanged.
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1), result handshake.
REQ-011 SHALL have ports out_sign / out_exponent / out_mantissa / out_guard, outputs, 1 / EXP_WIDTH / MANT_WIDTH+1 / 3, unrounded result: significand with explicit leading one, then guard, round, sticky.
REQ-012 SHALL have ports out_nan, out_inf, out_zero (1 bit each) and out_mode (3 bits), outputs.

Function
REQ-013 SHALL accept an operand on a cycle with in_valid and in_ready both high; in_ready SHALL be high only in IDLE.
REQ-014 SHALL implement FSM IDLE->PREP->ITER->NORM->DONE->IDLE; DONE->IDLE only on a cycle with out_ready high.
REQ-015 PREP SHALL decode: BIAS = 2^(EXP_WIDTH-1)-1; normal e = E-BIAS with significand 1.f; subnormal normalised by leading-zero count lz, giving e = 1-BIAS-lz.
REQ-016 PREP SHALL make the exponent even: e odd -> radicand = significand*2, e' = (e-1)/2; e even -> radicand = significand, e' = e/2 (arithmetic shift, signed).
REQ-017 ITER SHALL run restoring digit-by-digit square root; ROOT_BITS = MANT_WIDTH+3, ITERS = ceil(ROOT_BITS/BITS_PER_CYCLE), one ITER cycle per iteration, counter counting ITERS-1 down to 0.
REQ-018 Root SHALL lie in [1,2); out_mantissa = top MANT_WIDTH+1 root bits, out_guard[2:1] = next two bits, out_guard[0] = OR of nonzero remainder and any surplus root bit.
REQ-019 out_exponent SHALL equal e'+BIAS; out_sign SHALL be 0 for normal results.
REQ-020 With accept in cycle c, out_valid SHALL first be high in cycle c+ITERS+3 (c+29 at defaults).
REQ-021 Special operands: NaN or negative nonzero -> out_nan=1; +inf -> out_inf=1; +/-0 -> out_zero=1, out_sign = in_sign; all other flags 0.
REQ-022 Outputs SHALL hold stable while out_valid high and out_ready low; out_valid SHALL drop the cycle after the transfer.
REQ-023 in_* SHALL be registered at accept; input changes after accept SHALL not affect the result.

Reset
REQ-024 rst high SHALL force IDLE, out_valid=0, all out_* registers to 0, iteration counter to 0.
REQ-025 rst asserted mid-operation SHALL abandon the operation with no result emitted; in_ready high the cycle after rst falls.

Configuration
REQ-026 Macro FPU_SQRT_EARLY_EXIT_EN defined: special operands (REQ-021) SHALL go PREP->DONE, out_valid at c+2.
REQ-027 FPU_SQRT_EARLY_EXIT_EN undefined: special operands SHALL traverse all states with the REQ-020 latency, result flags as REQ-021.

Verification
REQ-028 0x40800000 (4.0) -> out_exponent=128, out_mantissa=0x800000, out_guard=0, out_valid at c+29.
REQ-029 0x40000000 (2.0) -> out_exponent=127, out_mantissa=0xB504F3, out_guard[0]=1.
REQ-030 0x00000002 (2^-148 subnormal) -> out_exponent=53, out_mantissa=0x800000, out_guard=0.
REQ-031 0xBF800000 (-1.0) -> out_nan=1; 0x80000000 -> out_zero=1, out_sign=1; with macro, latency 2.
REQ-032 out_ready low 5 cycles after out_valid -> outputs constant, in_ready low; transfer on release; next operand accepted the following cycle.
REQ-033 rst pulsed in ITER cycle 10 -> no out_valid; fresh 0x41800000 (16.0) then yields out_exponent=129, out_mantissa=0x800000.

Source files
------------

// File: rtl/fpu_sqrt_seq.sv
// Sequential IEEE square root: unpacks, runs a restoring digit recurrence, emits an unrounded
// significand plus guard/round/sticky. Define FPU_SQRT_EARLY_EXIT_EN to bypass ITER for specials.
module fpu_sqrt_seq #(
  parameter int unsigned EXP_WIDTH      = 8,
  parameter int unsigned MANT_WIDTH     = 23,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXP_WIDTH-1:0]  in_exponent,
  input  logic [MANT_WIDTH-1:0] in_mantissa,
  input  logic [2:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [EXP_WIDTH-1:0]  out_exponent,
  output logic [MANT_WIDTH:0]   out_mantissa,
  output logic [2:0]            out_guard,
  output logic                  out_nan,
  output logic                  out_inf,
  output logic                  out_zero,
  output logic [2:0]            out_mode
);

  localparam int unsigned BIAS      = (1 << (EXP_WIDTH - 1)) - 1;
  localparam int unsigned ROOT_BITS = MANT_WIDTH + 3;
  localparam int unsigned ITERS     = (ROOT_BITS + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int unsigned TOTAL     = ITERS * BITS_PER_CYCLE;
  localparam int unsigned RAD_W     = 2 * TOTAL;
  localparam int unsigned REM_W     = TOTAL + 2;
  localparam int unsigned SIG_W     = MANT_WIDTH + 1;
  localparam int unsigned CNT_W     = $clog2(ITERS + 1);
  localparam int unsigned EI_W      = EXP_WIDTH + $clog2(MANT_WIDTH + 1) + 2;

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StNorm, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    op_sign_q;
  logic [EXP_WIDTH-1:0]    op_exp_q;
  logic [MANT_WIDTH-1:0]   op_mant_q;
  logic [2:0]              mode_q;
  logic [RAD_W-1:0]        rad_q, rad_n, rad_init;
  logic [REM_W-1:0]        rem_q, rem_n, rem_t;
  logic [TOTAL-1:0]        root_q, root_n;
  logic [CNT_W-1:0]        cnt_q;
  logic [EXP_WIDTH-1:0]    res_exp_q, res_exp;

  logic                    exp_max, exp_zero, mant_zero, is_nan, is_inf, is_zero, special;
  int unsigned             lead, norm_shift;
  logic [SIG_W-1:0]        sig;
  logic [SIG_W:0]          sig_adj;
  logic signed [EI_W-1:0]  exp_unb, exp_half;
  logic                    sticky, load_out;

  assign exp_max   = &op_exp_q;
  assign exp_zero  = ~|op_exp_q;
  assign mant_zero = ~|op_mant_q;
  assign is_zero   = exp_zero && mant_zero;
  assign is_inf    = exp_max && mant_zero && !op_sign_q;
  assign is_nan    = (exp_max && !mant_zero) || (op_sign_q && !is_zero);
  assign special   = is_nan || is_inf || is_zero;
  assign in_ready  = (state_q == StIdle);

  // Unpack; subnormals are shifted so the leading one lands on the hidden-bit position.
  always_comb begin
    lead = 0;
    for (int i = 0; i < MANT_WIDTH; i++) begin
      if (op_mant_q[i]) lead = i;
    end
    norm_shift = MANT_WIDTH - lead;
    if (exp_zero) begin
      sig     = {1'b0, op_mant_q} << norm_shift;
      exp_unb = $signed(EI_W'(1)) - $signed(EI_W'(BIAS)) - $signed(EI_W'(norm_shift));
    end else begin
      sig     = {1'b1, op_mant_q};
      exp_unb = $signed(EI_W'(op_exp_q)) - $signed(EI_W'(BIAS));
    end
    exp_half = exp_unb >>> 1;
    res_exp  = EXP_WIDTH'(exp_half + $signed(EI_W'(BIAS)));
    sig_adj  = exp_unb[0] ? {sig, 1'b0} : {1'b0, sig};
    rad_init = {sig_adj, {(RAD_W - 2 - MANT_WIDTH){1'b0}}};
  end

  // Restoring recurrence: BITS_PER_CYCLE root bits per ITER cycle.
  always_comb begin
    rem_n  = rem_q;
    root_n = root_q;
    rad_n  = rad_q;
    rem_t  = '0;
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      rem_t = {rem_n[REM_W-3:0], rad_n[RAD_W-1 -: 2]};
      rad_n = rad_n << 2;
      if (rem_t >= {root_n, 2'b01}) begin
        rem_n  = rem_t - {root_n, 2'b01};
        root_n = {root_n[TOTAL-2:0], 1'b1};
      end else begin
        rem_n  = rem_t;
        root_n = {root_n[TOTAL-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    sticky = |rem_q;
    for (int i = 0; i < int'(TOTAL - ROOT_BITS); i++) begin
      sticky = sticky | root_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (in_valid) state_d = StPrep;
`ifdef FPU_SQRT_EARLY_EXIT_EN
      StPrep: state_d = special ? StDone : StIter;
`else
      StPrep: state_d = StIter;
`endif
      StIter: if (cnt_q == '0) state_d = StNorm;
      StNorm: state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign load_out = (state_q == StNorm) || (state_q == StPrep && state_d == StDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      op_sign_q    <= 1'b0;
      op_exp_q     <= '0;
      op_mant_q    <= '0;
      mode_q       <= '0;
      rad_q        <= '0;
      rem_q        <= '0;
      root_q       <= '0;
      cnt_q        <= '0;
      res_exp_q    <= '0;
      out_valid    <= 1'b0;
      out_sign     <= 1'b0;
      out_exponent <= '0;
      out_mantissa <= '0;
      out_guard    <= '0;
      out_nan      <= 1'b0;
      out_inf      <= 1'b0;
      out_zero     <= 1'b0;
      out_mode     <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d == StDone);
      if (state_q == StIdle && in_valid) begin
        op_sign_q <= in_sign;
        op_exp_q  <= in_exponent;
        op_mant_q <= in_mantissa;
        mode_q    <= in_mode;
      end
      if (state_q == StPrep) begin
        rad_q     <= rad_init;
        rem_q     <= '0;
        root_q    <= '0;
        cnt_q     <= CNT_W'(ITERS - 1);
        res_exp_q <= res_exp;
      end
      if (state_q == StIter) begin
        rad_q  <= rad_n;
        rem_q  <= rem_n;
        root_q <= root_n;
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end
      if (load_out) begin
        out_mode <= mode_q;
        out_nan  <= is_nan;
        out_inf  <= is_inf;
        out_zero <= is_zero;
        if (special) begin
          out_sign     <= is_zero && op_sign_q;
          out_exponent <= '0;
          out_mantissa <= '0;
          out_guard    <= '0;
        end else begin
          out_sign     <= 1'b0;
          out_exponent <= res_exp_q;
          out_mantissa <= root_q[TOTAL-1 -: SIG_W];
          out_guard    <= {root_q[TOTAL-SIG_W-1 -: 2], sticky};
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_sqrt_seq.sv
// Directed bench for fpu_sqrt_seq at default parameters (binary32).
module tb_fpu_sqrt_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign;
  logic [7:0]  in_exponent;
  logic [22:0] in_mantissa;
  logic [2:0]  in_mode;
  logic        out_valid, out_ready, out_sign;
  logic [7:0]  out_exponent;
  logic [23:0] out_mantissa;
  logic [2:0]  out_guard;
  logic        out_nan, out_inf, out_zero;
  logic [2:0]  out_mode;
  logic [41:0] res, snap;

  int errors = 0;
  int checks = 0;
  int lat;
  int seen;

`ifdef FPU_SQRT_EARLY_EXIT_EN
  localparam int SpecLat = 2;
`else
  localparam int SpecLat = 29;
`endif
  localparam int NormLat = 29;

  always #5 clk = ~clk;

  fpu_sqrt_seq dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exponent  (in_exponent),
    .in_mantissa  (in_mantissa),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sign     (out_sign),
    .out_exponent (out_exponent),
    .out_mantissa (out_mantissa),
    .out_guard    (out_guard),
    .out_nan      (out_nan),
    .out_inf      (out_inf),
    .out_zero     (out_zero),
    .out_mode     (out_mode)
  );

  assign res = {out_sign, out_exponent, out_mantissa, out_guard, out_nan, out_inf, out_zero,
                out_mode};

  function automatic logic [41:0] pk(logic s, logic [7:0] e, logic [23:0] m, logic [2:0] g,
                                     logic n, logic i, logic z, logic [2:0] md);
    return {s, e, m, g, n, i, z, md};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where out_valid is seen.
  task automatic run_op(input logic [31:0] op, input logic [2:0] md, output int l);
    check_eq("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid    = 1'b1;
    in_sign     = op[31];
    in_exponent = op[30:23];
    in_mantissa = op[22:0];
    in_mode     = md;
    @(posedge clk);
    @(negedge clk);
    in_valid    = 1'b0;
    in_sign     = ~op[31];
    in_exponent = ~op[30:23];
    in_mantissa = ~op[22:0];
    in_mode     = ~md;
    l = 1;
    while (!out_valid && l < 100) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] op, input logic [2:0] md,
                       input logic [41:0] exp_res, input int exp_lat);
    int l;
    run_op(op, md, l);
    check_eq({tag, "_lat"}, 64'(l), 64'(exp_lat));
    check_eq({tag, "_res"}, 64'(res), 64'(exp_res));
    @(negedge clk);
    check_eq({tag, "_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exponent = '0; in_mantissa = '0;
    in_mode = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_ready", 64'(in_ready), 64'd1);
    check_eq("rst_res", 64'(res), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("four", 32'h4080_0000, 3'd3, pk(0, 8'd128, 24'h800000, 3'b000, 0, 0, 0, 3'd3), NormLat);
    do_op("two", 32'h4000_0000, 3'd1, pk(0, 8'd127, 24'hB504F3, 3'b001, 0, 0, 0, 3'd1), NormLat);
    do_op("subn", 32'h0000_0002, 3'd0, pk(0, 8'd53, 24'h800000, 3'b000, 0, 0, 0, 3'd0), NormLat);
    do_op("neg1", 32'hBF80_0000, 3'd2, pk(0, 8'd0, 24'd0, 3'b000, 1, 0, 0, 3'd2), SpecLat);
    do_op("negz", 32'h8000_0000, 3'd4, pk(1, 8'd0, 24'd0, 3'b000, 0, 0, 1, 3'd4), SpecLat);
    do_op("pinf", 32'h7F80_0000, 3'd0, pk(0, 8'd0, 24'd0, 3'b000, 0, 1, 0, 3'd0), SpecLat);
    do_op("qnan", 32'h7FC0_0000, 3'd0, pk(0, 8'd0, 24'd0, 3'b000, 1, 0, 0, 3'd0), SpecLat);

    // Back-pressure: 9.0 held for five cycles, then 1.0 issued right after the transfer.
    out_ready = 1'b0;
    run_op(32'h4110_0000, 3'd5, lat);
    check_eq("hold_lat", 64'(lat), 64'(NormLat));
    check_eq("hold_res", 64'(res), 64'(pk(0, 8'd128, 24'hC00000, 3'b000, 0, 0, 0, 3'd5)));
    snap = res;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("hold_valid", 64'(out_valid), 64'd1);
      check_eq("hold_stable", 64'(res), 64'(snap));
      check_eq("hold_busy", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("rel_drop", 64'(out_valid), 64'd0);
    do_op("one", 32'h3F80_0000, 3'd0, pk(0, 8'd127, 24'h800000, 3'b000, 0, 0, 0, 3'd0), NormLat);

    // Reset during ITER cycle 10 abandons the operation.
    in_valid = 1'b1; in_sign = 1'b0; in_exponent = 8'h80; in_mantissa = '0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check_eq("mid_rst_novalid", 64'(seen), 64'd0);
    do_op("sixteen", 32'h4180_0000, 3'd0, pk(0, 8'd129, 24'h800000, 3'b000, 0, 0, 0, 3'd0),
          NormLat);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
